sram_line_packer: RTL

Byte-stream to line packer that feeds the on-chip SRAM test wrapper. It accepts 8-bit bytes over a valid/ready handshake and assembles them into 128-bit lines (16 bytes). Each completed line is written to consecutive SRAM line addresses through the wrapper's `write_enable`, `address` and `write_data` pins. It sits directly upstream of the SRAM wrapper and lets byte-serial producers fill memory that is later dumped for checking.

---
 rtl/sram_line_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_line_packer.sv
// Packs an 8-bit valid/ready byte stream into LINE_BYTES-wide lines and writes
// each line to consecutive SRAM line addresses, holding write_enable WRITE_HOLD cycles.
module sram_line_packer #(
  parameter int ADDR_BITS  = 16,
  parameter int LINE_BYTES = 16,
  parameter int BASE_ADDR  = 0,
  parameter int LAST_ADDR  = 511,
  parameter int WRITE_HOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sram_write_enable,
  output logic [ADDR_BITS-1:0]    sram_address,
  output logic [LINE_BYTES*8-1:0] sram_write_data,
  output logic [15:0]             lines_written,
  output logic                    full,
  output logic                    busy
);

  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int CW        = $clog2(LINE_BYTES + 1);
  localparam int HW        = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [LINE_BITS-1:0]   line_reg, line_next;
  logic [ADDR_BITS-1:0]   ptr_reg, ptr_next;
  logic [HW-1:0]          hold_reg, hold_next;
  logic [15:0]            lines_reg, lines_next;

  logic [LINE_BITS-1:0]   line_fill;
  logic [CW-1:0]          count_inc;
  logic [ADDR_BITS-1:0]   ptr_inc;
  logic [ADDR_BITS:0]     line_end;
  logic                   accept;
  logic                   line_done;
  logic                   hold_last;
  logic                   space_gone;

  assign accept     = (state_reg == FILL) && in_valid;
  assign count_inc  = count_reg + CW'(1);
  assign line_done  = (count_inc == CW'(LINE_BYTES));
  assign hold_last  = (hold_reg == HW'(WRITE_HOLD - 1));
  assign ptr_inc    = ptr_reg + ADDR_BITS'(LINE_BYTES);
  // One extra bit so the end-of-line check cannot wrap.
  assign line_end   = {1'b0, ptr_inc} + (ADDR_BITS + 1)'(LINE_BYTES - 1);
  assign space_gone = (line_end > (ADDR_BITS + 1)'(LAST_ADDR));

  // Incoming byte lands in lane `count`; other lanes keep their contents.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
      assign line_fill[gi*8 +: 8] = (count_reg == CW'(gi)) ? in_data : line_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      line_reg  <= '0;
      ptr_reg   <= ADDR_BITS'(BASE_ADDR);
      hold_reg  <= '0;
      lines_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      line_reg  <= line_next;
      ptr_reg   <= ptr_next;
      hold_reg  <= hold_next;
      lines_reg <= lines_next;
    end
  end

  // Unused lanes are already zero because the line register is cleared on
  // start and after every write, so a flush needs no explicit padding.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    line_next  = line_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    lines_next = lines_reg;

    case (state_reg)
      IDLE: ;
      FILL: begin
        if (accept) begin
          line_next  = line_fill;
          count_next = count_inc;
          if (line_done || flush) begin
            state_next = WRITE;
            hold_next  = '0;
          end
        end else if (flush && (count_reg != '0)) begin
          state_next = WRITE;
          hold_next  = '0;
        end
      end
      WRITE: begin
        if (hold_last) begin
          lines_next = lines_reg + 16'd1;
          ptr_next   = ptr_inc;
          count_next = '0;
          line_next  = '0;
          hold_next  = '0;
          state_next = space_gone ? DONE : FILL;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      DONE: ;
      default: state_next = IDLE;
    endcase

    if (start) begin
      state_next = FILL;
      count_next = '0;
      line_next  = '0;
      ptr_next   = ADDR_BITS'(BASE_ADDR);
      hold_next  = '0;
      lines_next = '0;
    end
  end

  assign in_ready          = (state_reg == FILL);
  assign sram_write_enable = (state_reg == WRITE);
  assign sram_address      = ptr_reg;
  assign sram_write_data   = line_reg;
  assign lines_written     = lines_reg;
  assign full              = (state_reg == DONE);
  assign busy              = (state_reg == WRITE) || ((state_reg == FILL) && (count_reg != '0));

endmodule
